// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a NUM_WORDS x 32 register memory; independent single-outstanding write/read engines.
// Optional WRAP burst support: define AXI_MEM_SLAVE_WRAP_EN.
module axi_mem_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_WORDS = 1024,
  parameter int          ID_WIDTH  = 2
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic [ID_WIDTH-1:0] s_axi_awid,
  input  logic [31:0]         s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_WIDTH-1:0] s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_WIDTH-1:0] s_axi_arid,
  input  logic [31:0]         s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_WIDTH-1:0] s_axi_rid,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int          AW   = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN = 32'(NUM_WORDS * 4);
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;
`ifdef AXI_MEM_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  function automatic logic in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off < SPAN;
  endfunction

  function automatic logic [AW-1:0] widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  // Whole-burst errors: evaluated once at the address handshake.
  function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    logic wrap_ok;
    wrap_ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (sz > 3'd2) || (bu == 2'b11) || (bu == 2'b10 && !wrap_ok);
  endfunction

  function automatic logic [31:0] nxt_addr(input logic [31:0] a, input logic [7:0] len,
                                           input logic [2:0] sz, input logic [1:0] bu);
    logic [31:0] inc, mask;
    inc  = 32'd1 << sz;
    mask = ((32'(len) + 32'd1) << sz) - 32'd1;
    if (bu == 2'b00)                return a;
    else if (bu == 2'b10 && WRAP_EN) return (a & ~mask) | ((a + inc) & mask);
    else                             return a + inc;
  endfunction

  logic [31:0] mem_q [NUM_WORDS];

  // ---------------- write engine ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  wstate_e             w_st_q;
  logic [31:0]         w_addr_q;
  logic [7:0]          w_len_q, w_beat_q;
  logic [2:0]          w_size_q;
  logic [1:0]          w_burst_q;
  logic                w_bad_q, w_err_q;
  logic [ID_WIDTH-1:0] w_id_q, bid_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic                aw_fire, w_fire, w_last, w_ok, w_we, w_beat_err;

  assign aw_fire    = awready_q & s_axi_awvalid;
  assign w_fire     = wready_q & s_axi_wvalid;
  assign w_last     = (w_beat_q == w_len_q);
  assign w_ok       = in_range(w_addr_q) & ~w_bad_q;
  assign w_we       = w_fire & w_ok;
  assign w_beat_err = ~w_ok | (s_axi_wlast != w_last);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      w_st_q <= W_IDLE; w_addr_q <= '0; w_len_q <= '0; w_beat_q <= '0; w_size_q <= '0;
      w_burst_q <= '0; w_bad_q <= 1'b0; w_err_q <= 1'b0; w_id_q <= '0; bid_q <= '0;
      awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= OKAY;
    end else begin
      case (w_st_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (aw_fire) begin
            w_id_q    <= s_axi_awid;    w_addr_q  <= s_axi_awaddr;
            w_len_q   <= s_axi_awlen;   w_size_q  <= s_axi_awsize;
            w_burst_q <= s_axi_awburst;
            w_bad_q   <= bad_burst(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            w_err_q   <= 1'b0;          w_beat_q  <= '0;
            awready_q <= 1'b0;          wready_q  <= 1'b1;
            w_st_q    <= W_DATA;
          end
        end
        W_DATA: if (w_fire) begin
          w_addr_q <= nxt_addr(w_addr_q, w_len_q, w_size_q, w_burst_q);
          w_beat_q <= w_beat_q + 8'd1;
          w_err_q  <= w_err_q | w_beat_err;
          // Beat count, not wlast, ends the burst.
          if (w_last) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bid_q    <= w_id_q;
            bresp_q  <= (w_err_q | w_beat_err) ? SLVERR : OKAY;
            w_st_q   <= W_RESP;
          end
        end
        W_RESP: if (s_axi_bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_st_q    <= W_IDLE;
        end
        default: w_st_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (s_axi_wstrb[b]) mem_q[widx(w_addr_q)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
    end
  end

  // ---------------- read engine ----------------
  typedef enum logic {R_IDLE, R_DATA} rstate_e;
  rstate_e             r_st_q;
  logic [31:0]         r_addr_q, rdata_q;
  logic [7:0]          r_len_q, r_beat_q;
  logic [2:0]          r_size_q;
  logic [1:0]          r_burst_q, rresp_q;
  logic                r_bad_q, arready_q, rvalid_q, rlast_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic                ar_fire, r_fire, r_ld_bad, r_ld_ok;
  logic [31:0]         r_ld_addr, r_ld_data;

  assign ar_fire = arready_q & s_axi_arvalid;
  assign r_fire  = rvalid_q & s_axi_rready;
  // Address/data of the beat loaded into the R registers this cycle (memory read sees pre-write value).
  assign r_ld_addr = ar_fire ? s_axi_araddr : nxt_addr(r_addr_q, r_len_q, r_size_q, r_burst_q);
  assign r_ld_bad  = ar_fire ? bad_burst(s_axi_arlen, s_axi_arsize, s_axi_arburst) : r_bad_q;
  assign r_ld_ok   = in_range(r_ld_addr) & ~r_ld_bad;
  assign r_ld_data = r_ld_ok ? mem_q[widx(r_ld_addr)] : '0;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_st_q <= R_IDLE; r_addr_q <= '0; r_len_q <= '0; r_beat_q <= '0; r_size_q <= '0;
      r_burst_q <= '0; r_bad_q <= 1'b0; rid_q <= '0; arready_q <= 1'b0; rvalid_q <= 1'b0;
      rdata_q <= '0; rresp_q <= OKAY; rlast_q <= 1'b0;
    end else begin
      case (r_st_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_fire) begin
            rid_q     <= s_axi_arid;    r_len_q  <= s_axi_arlen;
            r_size_q  <= s_axi_arsize;  r_burst_q <= s_axi_arburst;
            r_addr_q  <= r_ld_addr;     r_bad_q  <= r_ld_bad;
            r_beat_q  <= '0;            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;          rdata_q  <= r_ld_data;
            rresp_q   <= r_ld_ok ? OKAY : SLVERR;
            rlast_q   <= (s_axi_arlen == 8'd0);
            r_st_q    <= R_DATA;
          end
        end
        R_DATA: if (r_fire) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_st_q    <= R_IDLE;
          end else begin
            r_addr_q <= r_ld_addr;
            r_beat_q <= r_beat_q + 8'd1;
            rdata_q  <= r_ld_data;
            rresp_q  <= r_ld_ok ? OKAY : SLVERR;
            rlast_q  <= ((r_beat_q + 8'd1) == r_len_q);
          end
        end
        default: r_st_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rid     = rid_q;

  logic unused_ign;
  assign unused_ign = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
endmodule
